sram_controller: RTL and testbench
==================================

# sram_controller

Memory-side responder for the pipeline's MEM stage. It accepts the single-cycle read/write requests the EXE/MEM path issues (address = ALU result, write data = Val_Rm) and serves them from a 16-bit external SRAM as two half-word accesses plus a fixed wait. While busy it holds `ready` low so the pipeline freezes. It sits between the MEM stage and the board SRAM pins.

## Interface
Parameters:
- `WAIT_CYCLES`, 3: idle cycles after the second half-word access, modelling SRAM settle time; must be ≥1.
- `BASE_ADDR`, 32'd1024: CPU byte address mapped to SRAM half-word 0.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `rd_en`  in  1  read request from MEM stage; level, held until `ready`.
- `wr_en`  in  1  write request from MEM stage; level, held until `ready`.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  load result; valid while `ready`=1 in DONE.
- `ready`  out  1  0 = freeze pipeline; 1 = no access pending or access complete.
- `sram_addr`  out  18  half-word address to SRAM.
- `sram_dq_out`  out  16  write data to SRAM.
- `sram_dq_oe`  out  1  1 = drive `sram_dq_out` onto the bus.
- `sram_dq_in`  in  16  read data from SRAM bus.
- `sram_we_n`  out  1  SRAM write strobe, active low.

## Operation
- States: IDLE, LO, HI, WAIT, DONE.
- IDLE: `ready` = ~(`rd_en` | `wr_en`), combinational. On a request:
  - latch `address`, `write_data` and op;
  - go to LO.
  - If `rd_en` and `wr_en` are both high, the op is a write.
- Address mapping: off = address − `BASE_ADDR` (32-bit wrap). word = off[18:2]. LO uses {word,0}; HI uses {word,1}. off[1:0] and off[31:19] are ignored.
- LO: drive the low half-word address.
  - Write: `sram_dq_out` = wdata[15:0], `sram_dq_oe`=1, `sram_we_n`=0.
  - Read: register `sram_dq_in` into read_data[15:0] at the clock edge.
  - Next state: HI.
- HI: same as LO using the upper half (wdata[31:16] / read_data[31:16]). Next state: WAIT, counter cleared.
- WAIT: counter increments each cycle. After `WAIT_CYCLES` cycles go to DONE. `sram_we_n`=1, `sram_dq_oe`=0.
- DONE: `ready`=1 for exactly one cycle; `read_data` is stable. Next state: IDLE unconditionally.
  - A request still high in the following IDLE cycle is a new access. The pipeline advances on the DONE edge, so the next request is a new instruction.
- Requests are sampled only in IDLE. Input changes during LO/HI/WAIT are ignored because the values are latched.
- Writes do not modify `read_data`.

## Timing
- Reset values: state IDLE, `read_data`=0, counter=0, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0. `ready` follows the IDLE rule.
- Latency: the request is seen in IDLE at cycle 0. LO is cycle 1, HI cycle 2, WAIT cycles 3..2+`WAIT_CYCLES`, DONE cycle 3+`WAIT_CYCLES` (cycle 6 at default).
- Freeze length: `ready`=0 for 3+`WAIT_CYCLES` cycles per access.
- `sram_we_n` is low for exactly one cycle in LO and one in HI; it is never low in any other state.
- The SRAM must return data within the same cycle in LO/HI (asynchronous-read model).
- `rst` asserted in any state:
  - next cycle is IDLE with reset values;
  - a partially written word stays partially written;
  - the access is not retried.
- A request of zero cycles (deasserted in IDLE) starts nothing.

## Structure
- Shared package `arm_pkg`:
  - `sram_state_t` enum (IDLE, LO, HI, WAIT, DONE);
  - `SRAM_ADDR_W`=18, `SRAM_DATA_W`=16, `SRAM_BASE_ADDR`.
- Single module with no sub-module. The tri-state pad (`sram_dq_oe` driving the inout) lives at the top level.
- The bench uses a behavioural `sram_model` with 2^18×16 storage, a combinational read, and a write on `sram_we_n` low at the clock edge.

## Test plan
- Reset, then `wr_en` at 0x400 with data 0xDEADBEEF:
  - `ready` is 0 for 6 cycles;
  - model half-word 0 = 0xBEEF and half-word 1 = 0xDEAD;
  - `sram_we_n` is low only in cycles 1–2.
- `rd_en` at 0x400 after that write: at DONE (cycle 6) `ready`=1 and `read_data`=0xDEADBEEF; `sram_dq_oe` stays 0 throughout.
- Back-to-back: write 0x12345678 to 0x404, then hold `rd_en` at 0x404 immediately after DONE. The second access starts in the next IDLE and returns 0x12345678 at its DONE. Writes to 0x404 hit half-words 2 and 3.
- `rd_en` and `wr_en` both high with address 0x408 and data 0xA5A5_0F0F: the access is performed as a write; `read_data` is unchanged from its prior value.
- `rst` pulsed during WAIT of a read at 0x400: the next cycle is IDLE, `read_data`=0, `ready`=1 with no request, and no DONE pulse occurs.
- Request idle (`rd_en`=`wr_en`=0) for 10 cycles: `ready` stays 1, `sram_we_n`=1, state IDLE.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM-stage SRAM responder.
package arm_pkg;

  // Access sequencer states: idle, low half, high half, settle wait, one-cycle done
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } sram_state_t;

  localparam int          SRAM_ADDR_W    = 18;
  localparam int          SRAM_DATA_W    = 16;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage responder: serves a 32-bit load/store as two 16-bit SRAM
// accesses (low half, then high half) followed by a fixed settle wait.
// ready stays low for the whole access so the pipeline freezes.
module sram_controller
  import arm_pkg::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  // Counter only has to hold 0..WAIT_CYCLES-1
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

  sram_state_t         state_q, state_d;
  logic [16:0]         word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                is_write_q, is_write_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         read_data_q, read_data_d;
  logic [16:0]         req_word;

  // 32-bit word index relative to the SRAM window; byte offset and
  // bits above the 18-bit half-word space are dropped.
  assign req_word  = 17'((address - BASE_ADDR) >> 2);
  assign read_data = read_data_q;

  // Next-state and SRAM pin decode; pins are idle unless in LO/HI
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    case (state_q)
      IDLE: begin
        ready = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          word_d     = req_word;
          wdata_d    = write_data;
          is_write_d = wr_en;   // write wins when both are raised
          state_d    = LO;
        end
      end
      LO: begin
        sram_addr = {word_q, 1'b0};
        if (is_write_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end else begin
          read_data_d[15:0] = sram_dq_in;
        end
        state_d = HI;
      end
      HI: begin
        sram_addr = {word_q, 1'b1};
        if (is_write_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end else begin
          read_data_d[31:16] = sram_dq_in;
        end
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      cnt_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, reset/idle sequences,
// and randomized accesses checked against a word-level memory model.
module tb_sram_controller;
  import arm_pkg::*;

  localparam int          WAITC = 3;
  localparam logic [31:0] BASE  = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int total = 0;
  int bad   = 0;

  sram_controller #(.WAIT_CYCLES(WAITC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM model: asynchronous read, write on we_n low at the edge
  logic [15:0] mem [0:262143];
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  end

  // Reference: 32-bit words of the SRAM window plus last loaded value
  logic [31:0] ref_mem [0:15];
  logic [31:0] ref_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One access: raise request after an edge, watch each cycle until ready
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, output int freeze,
                            output logic [7:0] we_mask, output logic [7:0] oe_mask,
                            output logic [17:0] alo, output logic [17:0] ahi,
                            output logic [31:0] rdata, output logic timed_out);
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    freeze = 0; we_mask = '0; oe_mask = '0; alo = '0; ahi = '0;
    rdata = '0; timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 8) begin
        we_mask[i] = ~sram_we_n;
        oe_mask[i] = sram_dq_oe;
      end
      if (i == 1) alo = sram_addr;
      if (i == 2) ahi = sram_addr;
      if (ready) begin
        rdata = read_data;
        timed_out = 1'b0;
        break;
      end
      freeze++;
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_we;
    logic [17:0] exp_alo;
  } vec_t;

  vec_t vecs [6];

  int          freeze;
  logic [7:0]  we_mask, oe_mask;
  logic [17:0] alo, ahi;
  logic [31:0] rdata;
  logic        tmo;

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    ref_rd = 32'h0;

    // Back-to-back sequence: each access starts in the IDLE right after DONE
    vecs[0] = '{1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 32'h00000000, 8'h06, 18'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'hDEADBEEF, 8'h00, 18'd0};
    vecs[2] = '{1'b0, 1'b1, 32'h404, 32'h12345678, 32'hDEADBEEF, 8'h06, 18'd2};
    vecs[3] = '{1'b1, 1'b0, 32'h404, 32'h0,        32'h12345678, 8'h00, 18'd2};
    vecs[4] = '{1'b1, 1'b1, 32'h408, 32'hA5A50F0F, 32'h12345678, 8'h06, 18'd4};
    vecs[5] = '{1'b1, 1'b0, 32'h408, 32'h0,        32'hA5A50F0F, 8'h00, 18'd4};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_read_data", read_data, 32'h0);
    check("reset_we_n", 32'(sram_we_n), 32'd1);
    check("reset_oe", 32'(sram_dq_oe), 32'd0);
    check("reset_addr", 32'(sram_addr), 32'd0);
    check("reset_dq_out", 32'(sram_dq_out), 32'd0);

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      run_access(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                 freeze, we_mask, oe_mask, alo, ahi, rdata, tmo);
      check($sformatf("vec%0d_timeout", v), 32'(tmo), 32'd0);
      check($sformatf("vec%0d_freeze", v), 32'(freeze), 32'(3 + WAITC));
      check($sformatf("vec%0d_we_mask", v), 32'(we_mask), 32'(vecs[v].exp_we));
      check($sformatf("vec%0d_oe_mask", v), 32'(oe_mask), 32'(vecs[v].exp_we));
      check($sformatf("vec%0d_addr_lo", v), 32'(alo), 32'(vecs[v].exp_alo));
      check($sformatf("vec%0d_addr_hi", v), 32'(ahi), 32'(vecs[v].exp_alo) + 32'd1);
      check($sformatf("vec%0d_read_data", v), rdata, vecs[v].exp_rdata);
      $display("vec %0d rd=%0b wr=%0b addr=0x%08h rdata=0x%08h freeze=%0d",
               v, vecs[v].rd, vecs[v].wr, vecs[v].addr, rdata, freeze);
      if (vecs[v].wr) ref_mem[(vecs[v].addr - BASE) >> 2] = vecs[v].wdata;
      else            ref_rd = ref_mem[(vecs[v].addr - BASE) >> 2];
    end
    ref_rd = vecs[4].exp_rdata;
    ref_rd = ref_mem[2];
    check("hw0", 32'(mem[0]), 32'h0000BEEF);
    check("hw1", 32'(mem[1]), 32'h0000DEAD);
    check("hw2", 32'(mem[2]), 32'h00005678);
    check("hw3", 32'(mem[3]), 32'h00001234);
    check("hw4", 32'(mem[4]), 32'h00000F0F);
    check("hw5", 32'(mem[5]), 32'h0000A5A5);

    // Reset during the WAIT phase of a read: no DONE, read_data cleared
    @(posedge clk); #1;
    rd_en = 1'b1; wr_en = 1'b0; address = 32'h400;
    repeat (4) @(negedge clk);
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstwait_ready", 32'(ready), 32'd1);
    check("rstwait_read_data", read_data, 32'h0);
    check("rstwait_state", 32'(dut.state_q == IDLE), 32'd1);
    ref_rd = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rstwait_no_done", 32'(dut.state_q == IDLE), 32'd1);
      check("rstwait_rd_hold", read_data, 32'h0);
    end
    $display("reset-in-wait sequence read_data=0x%08h ready=%0b", read_data, ready);

    // Ten idle cycles with no request
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(sram_we_n), 32'd1);
      check("idle_state", 32'(dut.state_q == IDLE), 32'd1);
    end
    $display("idle sequence 10 cycles ready=%0b", ready);

    // Randomized accesses against the word-level model
    for (int n = 0; n < 40; n++) begin
      int          op, w, g;
      logic        rd, wr;
      logic [12:0] hi13;
      logic [1:0]  lo2;
      logic [16:0] w17;
      logic [31:0] off, a, d;
      op   = $urandom_range(0, 2);
      rd   = (op != 1);
      wr   = (op != 0);
      w    = $urandom_range(0, 15);
      w17  = 17'(w);
      hi13 = 13'($urandom);
      lo2  = 2'($urandom);
      off  = {hi13, w17, lo2};
      a    = off + BASE;
      d    = $urandom;
      run_access(rd, wr, a, d, freeze, we_mask, oe_mask, alo, ahi, rdata, tmo);
      if (wr) ref_mem[w] = d;
      else    ref_rd = ref_mem[w];
      check("rnd_timeout", 32'(tmo), 32'd0);
      check("rnd_freeze", 32'(freeze), 32'(3 + WAITC));
      check("rnd_we_mask", 32'(we_mask), wr ? 32'h6 : 32'h0);
      check("rnd_addr_lo", 32'(alo), 32'(2 * w));
      check("rnd_addr_hi", 32'(ahi), 32'(2 * w + 1));
      check("rnd_read_data", rdata, ref_rd);
      if (wr) begin
        check("rnd_mem_lo", 32'(mem[2 * w]), {16'h0, d[15:0]});
        check("rnd_mem_hi", 32'(mem[2 * w + 1]), {16'h0, d[31:16]});
      end
      $display("rnd %0d rd=%0b wr=%0b addr=0x%08h wdata=0x%08h rdata=0x%08h",
               n, rd, wr, a, d, rdata);
      g = $urandom_range(0, 2);
      if (g > 0) begin
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        repeat (g) @(posedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
